// File: rtl/fifo_memoria_param_if.sv
// Push/pop handshake, thresholds and status bus of the parametrised FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_memoria_param_if #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 4
);
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W:0]   afull_thr;
   logic [ADDR_W:0]   aempty_thr;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic              error;
   logic [ADDR_W:0]   count;

   modport master (
      output push, pop, data_in, afull_thr, aempty_thr,
      input  data_out, valid_out, full, empty, almost_full, almost_empty, error, count
   );

   modport slave (
      input  push, pop, data_in, afull_thr, aempty_thr,
      output data_out, valid_out, full, empty, almost_full, almost_empty, error, count
   );
endinterface

// File: rtl/fifo_memoria_param.sv
// Synchronous FIFO of 2**ADDR_W words with registered read data, valid strobe,
// programmable almost-full/almost-empty thresholds and a sticky over/underflow flag.
module fifo_memoria_param #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 4
) (
   input  logic               clk,
   input  logic               reset_L,
   fifo_memoria_param_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   typedef logic [ADDR_W-1:0] ptr_t;
   typedef logic [ADDR_W:0]   cnt_t;

   ptr_t                        wr_ptr_q, wr_ptr_d;
   ptr_t                        rd_ptr_q, rd_ptr_d;
   cnt_t                        count_q, count_d;
   logic [DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [DATA_W-1:0]           data_q, data_d;
   logic                        valid_q, valid_d;
   logic                        error_q, error_d;

   logic full, empty, wr_acc, rd_acc, ovf, unf;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // A push on a full FIFO still lands if a pop frees the slot in the same cycle;
   // a pop on an empty FIFO never reads the word being pushed.
   assign wr_acc = bus.push & (~full | bus.pop);
   assign rd_acc = bus.pop & ~empty;
   assign ovf    = bus.push & full & ~bus.pop;
   assign unf    = bus.pop & empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      data_d   = data_q;
      valid_d  = rd_acc;
      count_d  = count_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);
      error_d  = error_q | ovf | unf;
      if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + ptr_t'(1);
         data_d   = mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or posedge reset_L) begin
      if (reset_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
      end
   end

   // Storage is cleared on reset so stale words can never resurface after a restart.
   always_ff @(posedge clk or posedge reset_L) begin
      if (reset_L)     mem_q <= '0;
      else if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
   end

   assign bus.data_out     = data_q;
   assign bus.valid_out    = valid_q;
   assign bus.count        = count_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.error        = error_q;
   assign bus.almost_full  = (count_q >= bus.afull_thr);
   assign bus.almost_empty = (count_q <= bus.aempty_thr);
endmodule

// File: tb/tb_fifo_memoria_param.sv
// Directed bench for fifo_memoria_param: hand sequences for fill/drain/overflow/wrap/reset,
// and a vector table for the threshold and underflow case.
module tb_fifo_memoria_param;
   logic clk = 1'b0;
   logic reset_L;
   int   n_tests = 0;
   int   n_fail  = 0;

   fifo_memoria_param_if #(.DATA_W(10), .ADDR_W(4)) bus ();
   fifo_memoria_param #(.DATA_W(10), .ADDR_W(4)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       push;
      logic       pop;
      logic [9:0] din;
      logic [4:0] afthr;
      logic [4:0] aethr;
      int         cnt;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       vld;
      logic       err;
      logic [9:0] dout;
      logic       chk_d;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int cnt, input logic fl, input logic em,
                          input logic af, input logic ae, input logic vld, input logic err,
                          input logic [9:0] dout, input logic cd);
      chk({nm, ".count"}, 32'(bus.count), 32'(cnt));
      chk({nm, ".full"}, 32'(bus.full), 32'(fl));
      chk({nm, ".empty"}, 32'(bus.empty), 32'(em));
      chk({nm, ".almost_full"}, 32'(bus.almost_full), 32'(af));
      chk({nm, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
      chk({nm, ".valid_out"}, 32'(bus.valid_out), 32'(vld));
      chk({nm, ".error"}, 32'(bus.error), 32'(err));
      if (cd) chk({nm, ".data_out"}, 32'(bus.data_out), 32'(dout));
   endtask

   // Flags for the 14/2 thresholds used by the hand-written sequences.
   task automatic chk_seq(input string nm, input int cnt, input logic vld, input logic err,
                          input logic [9:0] dout, input logic cd);
      chk_all(nm, cnt, cnt == 16, cnt == 0, cnt >= 14, cnt <= 2, vld, err, dout, cd);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs sampled there too.
   task automatic drive(input logic p, input logic q, input logic [9:0] d);
      bus.push    = p;
      bus.pop     = q;
      bus.data_in = d;
      @(posedge clk);
      #1;
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
   endtask

   function automatic vec_t mk(input logic p, input logic q, input logic [9:0] d,
                               input logic [4:0] aft, input logic [4:0] aet, input int cnt,
                               input logic af, input logic ae, input logic vld, input logic err,
                               input logic [9:0] dout, input logic cd);
      vec_t v;
      v.push = p;  v.pop = q;  v.din = d;  v.afthr = aft;  v.aethr = aet;
      v.cnt = cnt; v.full = (cnt == 16); v.empty = (cnt == 0);
      v.af = af;   v.ae = ae;  v.vld = vld; v.err = err;  v.dout = dout; v.chk_d = cd;
      return v;
   endfunction

   initial begin
      // Threshold 12/3 table: 12 pushes, thr override row, 12 pops, underflow, afull_thr=0.
      for (int i = 1; i <= 12; i++)
         vt.push_back(mk(1, 0, 10'(12'h040 + i), 12, 3, i, i >= 12, i <= 3, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 12, 16, 12, 1, 1, 0, 0, 0, 0));
      for (int k = 1; k <= 12; k++)
         vt.push_back(mk(0, 1, 0, 12, 3, 12 - k, 0, (12 - k) <= 3, 1, 0, 10'(12'h040 + k), 1));
      vt.push_back(mk(0, 1, 0, 12, 3, 0, 0, 1, 0, 1, 10'h04C, 1));
      vt.push_back(mk(0, 0, 0, 0, 3, 0, 1, 1, 0, 1, 10'h04C, 1));

      bus.push = 0; bus.pop = 0; bus.data_in = 0;
      bus.afull_thr = 5'd14; bus.aempty_thr = 5'd2;
      reset_L = 1'b1;

      // 1: reset and idle
      @(posedge clk); @(posedge clk); #1;
      chk_seq("in_reset", 0, 0, 0, 10'h000, 1);
      reset_L = 1'b0;
      drive(0, 0, 0);
      chk_seq("idle", 0, 0, 0, 10'h000, 1);

      // 2: fill 16, drain 16
      for (int i = 1; i <= 16; i++) begin
         drive(1, 0, 10'(i));
         chk_seq($sformatf("fill%0d", i), i, 0, 0, 0, 0);
      end
      for (int i = 1; i <= 16; i++) begin
         drive(0, 1, 0);
         chk_seq($sformatf("drain%0d", i), 16 - i, 1, 0, 10'(i), 1);
      end
      drive(0, 0, 0);
      chk_seq("drained_idle", 0, 0, 0, 10'h010, 1);

      // 3: overflow drops the word
      for (int i = 1; i <= 16; i++) drive(1, 0, 10'(i));
      chk_seq("refill", 16, 0, 0, 0, 0);
      drive(1, 0, 10'h3FF);
      chk_seq("overflow", 16, 0, 1, 0, 0);
      drive(0, 1, 0);
      chk_seq("after_ovf_pop", 15, 1, 1, 10'h001, 1);

      // 4: simultaneous push/pop on full, then drain across the wrap
      drive(1, 0, 10'h011);
      chk_seq("full_again", 16, 0, 1, 0, 0);
      drive(1, 1, 10'h155);
      chk_seq("full_pushpop", 16, 1, 1, 10'h002, 1);
      for (int k = 3; k <= 16; k++) begin
         drive(0, 1, 0);
         chk_seq($sformatf("wrap_drain%0d", k), 18 - k, 1, 1, 10'(k), 1);
      end
      drive(0, 1, 0);
      chk_seq("pop_011", 1, 1, 1, 10'h011, 1);
      drive(0, 1, 0);
      chk_seq("pop_155", 0, 1, 1, 10'h155, 1);

      // 6: asynchronous reset with 7 words stored
      for (int i = 1; i <= 7; i++) drive(1, 0, 10'(12'h0A0 + i));
      chk_seq("pre_reset", 7, 0, 1, 10'h155, 1);
      #2 reset_L = 1'b1;
      #1;
      chk_seq("async_reset", 0, 0, 0, 10'h000, 1);
      drive(0, 1, 0);
      chk_seq("pop_in_reset", 0, 0, 0, 10'h000, 1);
      reset_L = 1'b0;

      // 5: table-driven thresholds and underflow
      foreach (vt[j]) begin
         bus.afull_thr  = vt[j].afthr;
         bus.aempty_thr = vt[j].aethr;
         drive(vt[j].push, vt[j].pop, vt[j].din);
         chk_all($sformatf("vec%0d", j), vt[j].cnt, vt[j].full, vt[j].empty, vt[j].af,
                 vt[j].ae, vt[j].vld, vt[j].err, vt[j].dout, vt[j].chk_d);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
